semaforo_multi: RTL and testbench

- Parametrised successor of the single-channel red/green turn/pedestrian light FSM. Drives N_CH red/green light pairs.
- Grants green to one channel at a time in round-robin order.
- Adds timed phases, a blinking-green warning phase, an all-red clearance interval, per-channel skip mask, and early-change request.
- Sits under the intersection top level, clocked by the low-frequency tick clock.

---
 rtl/semaforo_multi_if.sv | 27 ++
 rtl/semaforo_multi.sv | 170 +++++++++++++++++
 tb/tb_semaforo_multi.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/semaforo_multi_if.sv
// Control and lamp bundle for the multi-channel traffic light controller.
interface semaforo_multi_if #(
    parameter int unsigned N_CH = 4
);
    localparam int unsigned AW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            en;
    logic            set;
    logic            change;
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] green;
    logic [N_CH-1:0] red;
    logic [AW-1:0]   active_ch;
    logic [1:0]      phase;

    // Controller side: drives the commands and observes the lamps.
    modport master (
        output en, set, change, ch_en,
        input  green, red, active_ch, phase
    );

    // Light engine side.
    modport slave (
        input  en, set, change, ch_en,
        output green, red, active_ch, phase
    );
endinterface

// File: rtl/semaforo_multi.sv
// Round-robin multi-channel red/green light controller with timed green,
// blinking-green warning, all-red clearance, channel skip mask and early change.
module semaforo_multi #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned GREEN_TICKS = 8,
    parameter int unsigned BLINK_TICKS = 4,
    parameter int unsigned CLEAR_TICKS = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clklf,
    input  logic             reset,
    semaforo_multi_if.slave  bus
);
    localparam int unsigned AW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] GREEN_LD = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] BLINK_LD = CNT_W'(BLINK_TICKS - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_TICKS - 1);
    localparam logic [AW-1:0]    LAST_CH  = AW'(N_CH - 1);

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        GREEN = 2'b01,
        BLINK = 2'b10,
        CLEAR = 2'b11
    } phase_t;

    phase_t           phase_q, phase_d;
    logic [AW-1:0]    act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    logic [AW:0]      srch_cur;
    logic [AW:0]      srch_zero;
    logic [N_CH-1:0]  onehot_c;

    // Returns {found, index} of the first enabled channel after base, wrapping, ending at base.
    function automatic logic [AW:0] next_en(input logic [AW-1:0] base,
                                            input logic [N_CH-1:0] mask);
        logic          found;
        logic [AW-1:0] idx;
        int unsigned   j;
        found = 1'b0;
        idx   = base;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            j = (32'(base) + k) % N_CH;
            if (!found && mask[j]) begin
                found = 1'b1;
                idx   = AW'(j);
            end
        end
        return {found, idx};
    endfunction

    // Candidate grants: from the current channel and from the top (first grant from channel 0).
    always_comb begin
        srch_cur  = next_en(act_q, bus.ch_en);
        srch_zero = next_en(LAST_CH, bus.ch_en);
    end

    // State register with synchronous reset.
    always_ff @(posedge clklf) begin
        if (reset) begin
            phase_q <= OFF;
            act_q   <= '0;
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    // Next-state logic: phase sequencing, counter loads and channel selection.
    always_comb begin
        phase_d = phase_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (!bus.en) begin
            phase_d = OFF;
            cnt_d   = '0;
        end else begin
            case (phase_q)
                OFF: begin
                    if (!bus.set && srch_zero[AW]) begin
                        phase_d = GREEN;
                        act_d   = srch_zero[AW-1:0];
                        cnt_d   = GREEN_LD;
                    end else begin
                        phase_d = CLEAR;
                        act_d   = LAST_CH;
                        cnt_d   = CLEAR_LD;
                    end
                end
                GREEN: begin
                    if (cnt_q == '0 || bus.change || !bus.ch_en[act_q]) begin
                        if (BLINK_TICKS == 0) begin
                            phase_d = CLEAR;
                            cnt_d   = CLEAR_LD;
                        end else begin
                            phase_d = BLINK;
                            cnt_d   = BLINK_LD;
                            blink_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                BLINK: begin
                    blink_d = ~blink_q;
                    if (cnt_q == '0) begin
                        phase_d = CLEAR;
                        cnt_d   = CLEAR_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                CLEAR: begin
                    if (cnt_q == '0) begin
                        if (srch_cur[AW]) begin
                            phase_d = GREEN;
                            act_d   = srch_cur[AW-1:0];
                            cnt_d   = GREEN_LD;
                        end else begin
                            cnt_d = CLEAR_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    phase_d = CLEAR;
                    cnt_d   = CLEAR_LD;
                end
            endcase
        end
    end

    // Lamp decode from registered state; anything unexpected shows all red.
    always_comb begin
        onehot_c  = N_CH'(1) << act_q;
        bus.green = '0;
        bus.red   = '0;
        case (phase_q)
            OFF: begin
                bus.green = '0;
                bus.red   = '0;
            end
            GREEN: begin
                bus.green = onehot_c;
                bus.red   = ~onehot_c;
            end
            BLINK: begin
                bus.green = blink_q ? onehot_c : '0;
                bus.red   = ~onehot_c;
            end
            default: begin
                bus.green = '0;
                bus.red   = '1;
            end
        endcase
    end

    assign bus.active_ch = act_q;
    assign bus.phase     = phase_q;

endmodule

// File: tb/tb_semaforo_multi.sv
// Directed bench for semaforo_multi: N_CH=3, GREEN=4, BLINK=2, CLEAR=2.
module tb_semaforo_multi;
    logic clklf = 1'b0;
    logic reset;
    logic inv_on = 1'b0;
    int   checks = 0;
    int   errors = 0;

    semaforo_multi_if #(.N_CH(3)) bus ();

    semaforo_multi #(
        .N_CH(3), .GREEN_TICKS(4), .BLINK_TICKS(2), .CLEAR_TICKS(2), .CNT_W(8)
    ) dut (
        .clklf (clklf),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clklf = ~clklf;

    // Advance one edge and settle.
    task automatic tick();
        @(posedge clklf);
        #1;
    endtask

    // Compare lamps, phase and active channel against expected.
    task automatic check(input string tag, input logic [2:0] eg, input logic [2:0] er,
                         input logic [1:0] eph, input logic [1:0] eac);
        checks++;
        assert ({bus.green, bus.red, bus.phase, bus.active_ch} === {eg, er, eph, eac})
        else begin
            errors++;
            $error("FAIL %s: got g=%b r=%b ph=%b ac=%0d, expected g=%b r=%b ph=%b ac=%0d",
                   tag, bus.green, bus.red, bus.phase, bus.active_ch, eg, er, eph, eac);
        end
    endtask

    // Walk a full grant of channel ch starting at its first GREEN cycle; ends at the next grant.
    task automatic expect_grant(input int ch, input string tag);
        logic [2:0] oh;
        logic [1:0] ac;
        oh = 3'b001 << ch;
        ac = 2'(ch);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_green"}, oh, ~oh, 2'b01, ac);
            tick();
        end
        check({tag, "_blink_on"}, oh, ~oh, 2'b10, ac);
        tick();
        check({tag, "_blink_off"}, 3'b000, ~oh, 2'b10, ac);
        tick();
        check({tag, "_clear0"}, 3'b000, 3'b111, 2'b11, ac);
        tick();
        check({tag, "_clear1"}, 3'b000, 3'b111, 2'b11, ac);
        tick();
    endtask

    // One-green and no green+red overlap, every cycle once reset has been applied.
    always @(negedge clklf) begin
        if (inv_on) begin
            checks++;
            assert ($onehot0(bus.green) && ((bus.green & bus.red) == 3'b000))
            else begin
                errors++;
                $error("FAIL invariant: got g=%b r=%b, expected at most one green and no overlap",
                       bus.green, bus.red);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        bus.en     = 1'b0;
        bus.set    = 1'b0;
        bus.change = 1'b0;
        bus.ch_en  = 3'b111;
        tick();
        inv_on = 1'b1;
        check("reset", 3'b000, 3'b000, 2'b00, 2'd0);

        // Normal round robin from GREEN start, wrapping ch2 -> ch0.
        reset  = 1'b0;
        bus.en = 1'b1;
        tick();
        expect_grant(0, "rr_ch0");
        expect_grant(1, "rr_ch1");
        expect_grant(2, "rr_ch2");
        check("rr_wrap", 3'b001, 3'b110, 2'b01, 2'd0);

        // Start through CLEAR.
        reset = 1'b1;
        tick();
        check("reset2", 3'b000, 3'b000, 2'b00, 2'd0);
        reset   = 1'b0;
        bus.set = 1'b1;
        tick();
        check("set_clear0", 3'b000, 3'b111, 2'b11, 2'd2);
        tick();
        check("set_clear1", 3'b000, 3'b111, 2'b11, 2'd2);
        tick();
        check("set_green", 3'b001, 3'b110, 2'b01, 2'd0);

        // Skip mask: ch1 skipped, then nothing enabled, then ch1 restored.
        bus.ch_en = 3'b101;
        expect_grant(0, "skip_ch0");
        check("skip_green2", 3'b100, 3'b011, 2'b01, 2'd2);
        bus.ch_en = 3'b000;
        tick();
        check("none_blink_on", 3'b100, 3'b011, 2'b10, 2'd2);
        tick();
        check("none_blink_off", 3'b000, 3'b011, 2'b10, 2'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("none_hold_clear", 3'b000, 3'b111, 2'b11, 2'd2);
        end
        bus.ch_en = 3'b010;
        tick();
        check("restore_clear", 3'b000, 3'b111, 2'b11, 2'd2);
        tick();
        check("restore_green1", 3'b010, 3'b101, 2'b01, 2'd1);

        // Early change on second GREEN cycle; change ignored in CLEAR.
        bus.ch_en = 3'b111;
        tick();
        check("chg_green2", 3'b010, 3'b101, 2'b01, 2'd1);
        bus.change = 1'b1;
        tick();
        check("chg_blink_on", 3'b010, 3'b101, 2'b10, 2'd1);
        bus.change = 1'b0;
        tick();
        check("chg_blink_off", 3'b000, 3'b101, 2'b10, 2'd1);
        tick();
        check("chg_clear0", 3'b000, 3'b111, 2'b11, 2'd1);
        bus.change = 1'b1;
        tick();
        check("chg_clear1", 3'b000, 3'b111, 2'b11, 2'd1);
        tick();
        check("chg_green_ch2", 3'b100, 3'b011, 2'b01, 2'd2);
        bus.change = 1'b0;

        // Enable dropped mid-BLINK, then restart from channel 0.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_green", 3'b100, 3'b011, 2'b01, 2'd2);
        end
        tick();
        check("en_blink_on", 3'b100, 3'b011, 2'b10, 2'd2);
        bus.en = 1'b0;
        tick();
        check("en_off", 3'b000, 3'b000, 2'b00, 2'd2);
        bus.en  = 1'b1;
        bus.set = 1'b0;
        tick();
        check("en_restart", 3'b001, 3'b110, 2'b01, 2'd0);

        // Reset together with change during ch1 GREEN.
        expect_grant(0, "rst_ch0");
        tick();
        check("rst_pre", 3'b010, 3'b101, 2'b01, 2'd1);
        reset      = 1'b1;
        bus.change = 1'b1;
        tick();
        check("rst_mid_green", 3'b000, 3'b000, 2'b00, 2'd0);
        reset      = 1'b0;
        bus.change = 1'b0;
        bus.en     = 1'b0;
        tick();
        check("final_off", 3'b000, 3'b000, 2'b00, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
